approx_mult_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the 8x8 approximate multiplier.
- Time-multiplexes ONE approx_mult_4bit instance over the four nibble partial products instead of using four parallel instances.
- Handshake on input and output; accumulates shifted partial products into a 16-bit result.
- Drives a per-step activity enable so the shared multiplier's operand path can be clock-gated, with optional zero-nibble skipping for power.

---
 rtl/approx_mult_pkg.sv | 18 +
 rtl/approx_mult_4bit.sv | 14 +
 rtl/approx_mult_seq_ctrl.sv | 112 +++++++++++
 tb/tb_approx_mult_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and step tables for the sequential 8x8 approximate multiplier.
// Step order: aLxbL, aHxbL, aLxbH, aHxbH.
package approx_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Packed per-step shift amounts, step 0 in the low nibble: {8,4,4,0}
    localparam logic [15:0] STEP_SHIFT = {4'd8, 4'd4, 4'd4, 4'd0};

    // Bit s set: step s takes the high nibble of that operand
    localparam logic [3:0] SEL_A_HI = 4'b1010;
    localparam logic [3:0] SEL_B_HI = 4'b1100;

endpackage

// File: rtl/approx_mult_4bit.sv
// 4x4 approximate multiplier: exact product with the two
// least-significant product bits truncated to zero.
module approx_mult_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_full;

    assign w_full = {4'd0, i_a} * {4'd0, i_b};
    assign o_p    = {w_full[7:2], 2'b00};

endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// Sequencer sharing one approx_mult_4bit across four nibble steps,
// with valid/ready handshakes and optional zero-nibble skipping.
module approx_mult_seq_ctrl
    import approx_mult_pkg::*;
#(
    parameter int SKIP_ZERO = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      y,
    output logic             busy,
    output logic             mult_en,
    output logic [CNT_W-1:0] skip_cnt
);

    state_t           r_state;
    logic [1:0]       r_step;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [15:0]      r_acc;
    logic [15:0]      r_y;
    logic [3:0]       r_ma;
    logic [3:0]       r_mb;
    logic [CNT_W-1:0] r_skip;

    logic [3:0]  w_na;
    logic [3:0]  w_nb;
    logic        w_calc;
    logic        w_skip;
    logic        w_en;
    logic [3:0]  w_ma;
    logic [3:0]  w_mb;
    logic [7:0]  w_p;
    logic [3:0]  w_sh;
    logic [15:0] w_add;
    logic [15:0] w_sum;
    logic        w_accept;

    assign w_na   = SEL_A_HI[r_step] ? r_a[7:4] : r_a[3:0];
    assign w_nb   = SEL_B_HI[r_step] ? r_b[7:4] : r_b[3:0];
    assign w_calc = (r_state == CALC);
    assign w_skip = (SKIP_ZERO != 0) && ((w_na == 4'd0) || (w_nb == 4'd0));
    assign w_en   = w_calc && !w_skip;

    // Operand path only toggles on active steps so it can be gated
    assign w_ma = w_en ? w_na : r_ma;
    assign w_mb = w_en ? w_nb : r_mb;

    approx_mult_4bit u_mult (
        .i_a (w_ma),
        .i_b (w_mb),
        .o_p (w_p)
    );

    assign w_sh  = STEP_SHIFT[{r_step, 2'b00} +: 4];
    assign w_add = w_en ? ({8'd0, w_p} << w_sh) : 16'd0;
    assign w_sum = r_acc + w_add;

    assign in_ready = !rst && ((r_state == IDLE) ||
                               ((r_state == DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= 2'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_acc   <= 16'd0;
            r_y     <= 16'd0;
            r_ma    <= 4'd0;
            r_mb    <= 4'd0;
            r_skip  <= '0;
        end else begin
            r_ma <= w_ma;
            r_mb <= w_mb;
            if (w_calc) begin
                r_acc  <= w_sum;
                r_step <= r_step + 2'd1;
                if (w_skip && (r_skip != {CNT_W{1'b1}})) begin
                    r_skip <= r_skip + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (r_step == 2'd3) begin
                    r_state <= DONE;
                    r_y     <= w_sum;
                end
            end else if (w_accept) begin
                r_state <= CALC;
                r_step  <= 2'd0;
                r_acc   <= 16'd0;
                r_a     <= a;
                r_b     <= b;
            end else if ((r_state == DONE) && out_ready) begin
                r_state <= IDLE;
            end
        end
    end

    assign out_valid = (r_state == DONE);
    assign y         = r_y;
    assign busy      = w_calc;
    assign mult_en   = w_en;
    assign skip_cnt  = r_skip;

endmodule

// File: tb/tb_approx_mult_seq_ctrl.sv
// Scoreboard bench for approx_mult_seq_ctrl: directed cases plus
// randomized traffic against an arithmetic reference model.
module tb_approx_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;

    logic        in_ready, out_valid, busy, mult_en;
    logic [15:0] y;
    logic [15:0] skip_cnt;
    logic        in_ready0, out_valid0, busy0, mult_en0;
    logic [15:0] y0;
    logic [15:0] skip_cnt0;

    int          total = 0;
    int          bad = 0;
    int          skip_model = 0;
    bit          rnd_en = 1'b0;
    logic [15:0] expq[$];

    approx_mult_seq_ctrl #(.SKIP_ZERO(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy), .mult_en(mult_en), .skip_cnt(skip_cnt)
    );

    approx_mult_seq_ctrl #(.SKIP_ZERO(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .y(y0), .busy(busy0), .mult_en(mult_en0), .skip_cnt(skip_cnt0)
    );

    always #5 clk = ~clk;

    // 4x4 approximate product: exact product with bits [1:0] dropped
    function automatic int ap4(input int x, input int z);
        return (x * z) & 32'hFC;
    endfunction

    function automatic int ref8(input int a8, input int b8);
        int al, ah, bl, bh;
        al = a8 % 16; ah = a8 / 16;
        bl = b8 % 16; bh = b8 / 16;
        return (ap4(al, bl) + ap4(ah, bl) * 16 +
                ap4(al, bh) * 16 + ap4(ah, bh) * 256) % 65536;
    endfunction

    function automatic logic [3:0] en_mask(input int a8, input int b8);
        int al, ah, bl, bh;
        logic [3:0] m;
        al = a8 % 16; ah = a8 / 16;
        bl = b8 % 16; bh = b8 / 16;
        m[0] = (al != 0) && (bl != 0);
        m[1] = (ah != 0) && (bl != 0);
        m[2] = (al != 0) && (bh != 0);
        m[3] = (ah != 0) && (bh != 0);
        return m;
    endfunction

    function automatic logic [3:0] rnib();
        if ($urandom_range(0, 3) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer an operand pair until it is accepted; leaves time at edge+1
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        expq.push_back(16'(ref8(int'(ia), int'(ib))));
        skip_model += 4 - $countones(en_mask(int'(ia), int'(ib)));
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    // Follow the four CALC cycles and the first DONE cycle
    task automatic observe(input logic [7:0] ia, input logic [7:0] ib);
        logic [3:0] en;
        logic [3:0] en0;
        en = 4'd0;
        en0 = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("calc_flags", int'({in_ready, busy, out_valid}), 2);
            en[i] = mult_en;
            en0[i] = mult_en0;
        end
        check("mult_en_steps", int'(en), int'(en_mask(int'(ia), int'(ib))));
        check("mult_en_noskip", int'(en0), 15);
        @(negedge clk);
        check("done_valid", int'(out_valid), 1);
        check("done_y", int'(y), ref8(int'(ia), int'(ib)));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result y=%0h", y);
            end else begin
                logic [15:0] e;
                e = expq.pop_front();
                check("result_y", int'(y), int'(e));
                check("result_y_noskip", int'(y0), int'(e));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", int'(in_ready), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_flags", int'({out_valid, busy, mult_en, in_ready}), 1);
        check("rst_y", int'(y), 0);
        check("rst_skip", int'(skip_cnt), 0);

        // Basic operation
        tick();
        out_ready = 1'b1;
        issue(8'h12, 8'h34);
        observe(8'h12, 8'h34);

        // Zero-nibble skipping
        tick();
        issue(8'h0F, 8'hF0);
        observe(8'h0F, 8'hF0);
        check("skip_cnt_after_zero", int'(skip_cnt), 3);
        check("skip_cnt_noskip", int'(skip_cnt0), 0);

        // Backpressure hold
        tick();
        out_ready = 1'b0;
        issue(8'hFF, 8'hFF);
        observe(8'hFF, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_flags", int'({out_valid, in_ready}), 2);
            check("hold_y", int'(y), ref8(255, 255));
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_valid", int'({out_valid, busy}), 0);

        // Back-to-back accept from DONE
        tick();
        out_ready = 1'b0;
        issue(8'h34, 8'h12);
        observe(8'h34, 8'h12);
        tick();
        out_ready = 1'b1;
        issue(8'h21, 8'h43);
        observe(8'h21, 8'h43);

        // Reset in the middle of an operation
        tick();
        issue(8'hAB, 8'hCD);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expq.delete();
        skip_model = 0;
        @(negedge clk);
        check("abort_flags", int'({out_valid, busy, mult_en, in_ready}), 1);
        check("abort_y", int'(y), 0);
        check("abort_skip", int'(skip_cnt), 0);
        tick();
        issue(8'h11, 8'h11);
        observe(8'h11, 8'h11);

        // Randomized traffic with random backpressure
        tick();
        rnd_en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            issue({rnib(), rnib()}, {rnib(), rnib()});
            repeat ($urandom_range(0, 2)) tick();
        end
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", expq.size(), 0);
        check("skip_cnt_total", int'(skip_cnt), skip_model);
        check("skip_cnt_total_noskip", int'(skip_cnt0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
